// File: rtl/imem_loader.sv
// Byte-stream loader that writes program words into instruction memory while the core is held in reset.
// Latency: imem_we 1 cycle after a word's 4th byte; backpressure: in_ready low outside a session (optional checksum: IMEM_LOADER_CKSUM_EN).
// in_ready drops in the same cycle as abort and while the last word's strobe is pending; bytes are then left unconsumed.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAP = 17'(2**ADDR_W);

    state_t          state, state_nxt;
    logic [15:0]     cnt;
    logic [ADDR_W:0] index;
    logic [23:0]     sh;
    logic [1:0]      bcnt;
    logic [15:0]     n_full;
    logic            last_word;
    logic            xfer;
    logic            load_start;
    logic            abort_go;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]      cksum;
`else
    logic            last_pend;
`endif

    assign n_full     = {cnt[15:8], in_data};
    assign last_word  = (17'(index) + 17'd1) == {1'b0, cnt};
    assign xfer       = in_valid & in_ready;
    assign abort_go   = abort && (state != S_IDLE);
    // CNT_HI is reachable only through an accepted start
    assign load_start = (state_nxt == S_CNT_HI) && (state != S_CNT_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            S_IDLE: if (start) state_nxt = S_CNT_HI;
            S_CNT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_full == 16'd0)            state_nxt = S_DONE;
                    else if ({1'b0, n_full} > CAP)  state_nxt = S_ERR;
                    else                            state_nxt = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && bcnt == 2'd3 && last_word) state_nxt = S_CKSUM;
            end
            S_CKSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ((cksum ^ in_data) == 8'd0) ? S_DONE : S_ERR;
            end
`else
            // Finish only after the last strobe so the core never runs during a write
            S_DATA: begin
                in_ready = !last_pend;
                if (last_pend) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = S_CNT_HI;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nxt = S_CNT_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort_go) begin
            state_nxt = S_IDLE;
            in_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            cnt        <= 16'd0;
            index      <= '0;
            sh         <= 24'd0;
            bcnt       <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum      <= 8'd0;
`else
            last_pend  <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (imem_we) index <= index + (ADDR_W+1)'(1);
            if (load_start || abort_go) begin
                index <= '0;
                bcnt  <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum <= 8'd0;
`else
                last_pend <= 1'b0;
`endif
            end else if (xfer) begin
                case (state)
                    S_CNT_HI: cnt[15:8] <= in_data;
                    S_CNT_LO: cnt[7:0]  <= in_data;
                    S_DATA: begin
                        sh   <= {sh[15:0], in_data};
                        bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                        cksum <= cksum ^ in_data;
`endif
                        if (bcnt == 2'd3) begin
                            imem_wdata <= {sh, in_data};
                            imem_addr  <= BASE_ADDR + 32'({index, 2'b00});
                            imem_we    <= 1'b1;
`ifndef IMEM_LOADER_CKSUM_EN
                            if (last_word) last_pend <= 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, write strobes, count limits, abort, reset and gappy input.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_addr, imem_wdata;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [7:0]  tx[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Capture every strobe; the core must still be held while it is written
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            check("hold_during_we", 32'(cpu_hold), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            in_valid = 1'b0;
            tick(gap);
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("rdy_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int gap_max);
        foreach (tx[i]) send_byte(tx[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    endtask

    // Two-word reference frame, plus its checksum byte when that feature is built
    task automatic frame2(input int gap_max);
        tx = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CKSUM_EN
        tx.push_back(8'h08);
`endif
        send_all(gap_max);
    endtask

    task automatic check_two(input string tag);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea = '{BASE, BASE + 32'd4};
        ed = '{32'h1234_5678, 32'hAABB_CCDD};
        check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        for (int i = 0; i < wa.size() && i < 2; i++) begin
            check({tag, "_addr"}, wa[i], ea[i]);
            check({tag, "_data"}, wd[i], ed[i]);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(error), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(3);
        @(negedge clk);
        check("rst_rdy",   32'(in_ready), 32'd0);
        check("rst_we",    32'(imem_we),  32'd0);
        check("rst_addr",  imem_addr,     BASE);
        check("rst_wdata", imem_wdata,    32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd1);
        check("rst_done",  32'(done),     32'd0);
        check("rst_err",   32'(error),    32'd0);
        tick(1);
        reset = 1'b1;
        tick(2);

        // Byte offered in IDLE is not taken
        in_data = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        check("idle_rdy", 32'(in_ready), 32'd0);
        tick(1);
        in_valid = 1'b0;

        // Reference frame, back-to-back bytes
        wa.delete(); wd.delete();
        pulse_start();
        frame2(0);
        tick(3);
        check_two("b2b");
        in_data = 8'h55; in_valid = 1'b1;
        @(negedge clk);
        check("done_rdy", 32'(in_ready), 32'd0);
        tick(1);
        in_valid = 1'b0;

`ifdef IMEM_LOADER_CKSUM_EN
        wa.delete(); wd.delete();
        pulse_start();
        tx = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_all(0);
        tick(3);
        check("badck_nwr",  32'(wa.size()), 32'd2);
        check("badck_err",  32'(error),     32'd1);
        check("badck_done", 32'(done),      32'd0);
        check("badck_hold", 32'(cpu_hold),  32'd1);
`endif

        // Zero count finishes without writes
        wa.delete(); wd.delete();
        pulse_start();
        check("restart_done", 32'(done), 32'd0);
        tx = '{8'h00, 8'h00};
        send_all(0);
        tick(2);
        check("n0_nwr",  32'(wa.size()), 32'd0);
        check("n0_done", 32'(done),       32'd1);
        check("n0_hold", 32'(cpu_hold),   32'd0);

        // Count one past capacity is rejected
        pulse_start();
        tx = '{8'h01, 8'h01};
        send_all(0);
        tick(2);
        check("ovf_nwr",  32'(wa.size()), 32'd0);
        check("ovf_err",  32'(error),     32'd1);
        check("ovf_done", 32'(done),      32'd0);
        check("ovf_hold", 32'(cpu_hold),  32'd1);
        check("ovf_rdy",  32'(in_ready),  32'd0);
        pulse_abort();
        check("ovf_abort_err", 32'(error), 32'd0);

        // Count equal to capacity fills memory exactly
        wa.delete(); wd.delete();
        pulse_start();
        tx = '{8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) tx.push_back(i[7:0]);
`ifdef IMEM_LOADER_CKSUM_EN
        tx.push_back(8'h00);
`endif
        send_all(0);
        tick(3);
        check("full_nwr", 32'(wa.size()), 32'd256);
        if (wa.size() == 256) begin
            check("full_a0",   wa[0],   BASE);
            check("full_d0",   wd[0],   32'h0001_0203);
            check("full_alst", wa[255], BASE + 32'h3FC);
            check("full_dlst", wd[255], 32'hFCFD_FEFF);
        end
        check("full_done", 32'(done), 32'd1);

        // Reset in the middle of a data word
        wa.delete(); wd.delete();
        pulse_start();
        tx = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_all(0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy",  32'(in_ready), 32'd0);
        check("mid_rst_we",   32'(imem_we),  32'd0);
        check("mid_rst_addr", imem_addr,     BASE);
        check("mid_rst_wd",   imem_wdata,    32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_done", 32'(done),     32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Abort after two data bytes, then reload from the base address
        pulse_start();
        tx = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_all(0);
        pulse_abort();
        tick(2);
        check("abort_nwr",  32'(wa.size()), 32'd0);
        check("abort_rdy",  32'(in_ready),  32'd0);
        check("abort_hold", 32'(cpu_hold),  32'd1);
        check("abort_done", 32'(done),      32'd0);
        pulse_start();
        frame2(0);
        tick(3);
        check_two("reload");

        // Same frame with random gaps in in_valid
        wa.delete(); wd.delete();
        pulse_start();
        frame2(3);
        tick(3);
        check_two("gappy");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
